// File: rtl/fetch_unit.sv
// GB80 instruction prefetch unit: fetches bytes from the memory bus into a small FIFO and
// streams them to the decoder. Optional fetch hold input enabled by `define GB80_FETCH_HOLD_EN.
module fetch_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 16,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic [PC_WIDTH-1:0]   o_bus_addr,
  output logic                  o_bus_rd,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_data,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [PC_WIDTH-1:0]   o_byte_pc,
  input  logic                  i_flush,
  input  logic [PC_WIDTH-1:0]   i_flush_pc
`ifdef GB80_FETCH_HOLD_EN
  ,
  input  logic                  i_hold
`endif
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  head, tail, head_next;
  logic [CW-1:0]         count, count_next, count_after_pop;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  push, pop, hold;

`ifdef GB80_FETCH_HOLD_EN
  assign hold = i_hold;
`else
  assign hold = 1'b0;
`endif

  // A flush wins over both queue operations; a byte acked during a flush is dropped.
  assign push = (state == REQ) & i_bus_ack & ~i_flush;
  assign pop  = o_data_valid & i_data_ready & ~i_flush;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    head_next       = head + PTR_WIDTH'(pop);
    count_after_pop = count - CW'(pop);
    count_next      = count_after_pop + CW'(push);
    data_next       = o_data_out;
    if (count_after_pop != '0) data_next = mem[head_next];
    else if (push)             data_next = i_bus_data;
  end

  // NOTE: queue storage has no reset; count/valid guard every read of it.
  always_ff @(posedge i_clk) begin
    if (push) mem[tail] <= i_bus_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      fetch_pc     <= '0;
      o_bus_rd     <= 1'b0;
      o_bus_addr   <= '0;
      o_data_out   <= '0;
      o_data_valid <= 1'b0;
      o_byte_pc    <= '0;
    end else begin
      if (i_flush) begin
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        o_data_valid <= 1'b0;
        o_byte_pc    <= i_flush_pc;
        fetch_pc     <= i_flush_pc;
      end else begin
        head         <= head_next;
        tail         <= tail + PTR_WIDTH'(push);
        count        <= count_next;
        o_data_valid <= (count_next != '0);
        o_data_out   <= data_next;
        if (pop)  o_byte_pc <= o_byte_pc + PC_WIDTH'(1);
        if (push) fetch_pc  <= fetch_pc + PC_WIDTH'(1);
      end

      // The bus cycle is never aborted: o_bus_rd/o_bus_addr only move on ack or from IDLE.
      case (state)
        IDLE: begin
          if (!i_flush && !hold && count < DEPTH_C) begin
            state      <= REQ;
            o_bus_rd   <= 1'b1;
            o_bus_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (i_bus_ack) begin
            if (!i_flush && !hold && count_next < DEPTH_C) begin
              o_bus_addr <= fetch_pc + PC_WIDTH'(1);
            end else begin
              state    <= IDLE;
              o_bus_rd <= 1'b0;
            end
          end else if (i_flush) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (i_bus_ack) begin
            state    <= IDLE;
            o_bus_rd <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          o_bus_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected (address, byte) pairs filled on
// accepted bus acks and drained on consumer pops; bus data is a fixed function of address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_ack;
  logic [7:0]  bus_data;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] byte_pc;
  logic        flush;
  logic [15:0] flush_pc;
`ifdef GB80_FETCH_HOLD_EN
  logic        hold;
`endif

  fetch_unit dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .o_bus_addr   (bus_addr),
    .o_bus_rd     (bus_rd),
    .i_bus_ack    (bus_ack),
    .i_bus_data   (bus_data),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .i_data_ready (data_ready),
    .o_byte_pc    (byte_pc),
    .i_flush      (flush),
    .i_flush_pc   (flush_pc)
`ifdef GB80_FETCH_HOLD_EN
    ,
    .i_hold       (hold)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t      exp_q[$];
  logic [15:0] exp_pc;
  logic        discarding;
  logic        pend;
  logic [15:0] pend_addr;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  function automatic logic [7:0] bus_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // One clock cycle: check outputs at the falling edge, drive inputs, update the model.
  task automatic step(input logic ack, input logic rdy, input logic fl, input logic [15:0] fpc);
    check("valid", data_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("data_out", data_out, exp_q[0].data);
      check("byte_pc", byte_pc, exp_q[0].addr);
    end
    if (pend) begin
      check("rd_held", bus_rd, 1);
      check("addr_held", bus_addr, pend_addr);
    end
    bus_ack    = ack;
    bus_data   = ack ? bus_byte(bus_addr) : 8'h00;
    data_ready = rdy;
    flush      = fl;
    flush_pc   = fpc;
    if (fl) begin
      exp_q.delete();
      exp_pc     = fpc;
      discarding = bus_rd && !ack;
    end else begin
      if (bus_rd && ack && !discarding) begin
        check("fetch_addr", bus_addr, exp_pc);
        check("no_overflow", exp_q.size() < 4, 1);
      end
      if (data_valid && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (bus_rd && ack) begin
        if (discarding) discarding = 1'b0;
        else begin
          exp_q.push_back('{addr: exp_pc, data: bus_byte(exp_pc)});
          exp_pc = exp_pc + 16'd1;
        end
      end
    end
    pend      = bus_rd && !ack;
    pend_addr = bus_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_data = 8'h00; data_ready = 1'b0;
    flush = 1'b0; flush_pc = 16'h0000;
`ifdef GB80_FETCH_HOLD_EN
    hold = 1'b0;
`endif
    exp_pc = 16'h0000; discarding = 1'b0; pend = 1'b0; pend_addr = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_rd", bus_rd, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_byte_pc", byte_pc, 0);
    rst = 1'b0;

    // Back-to-back zero-wait acks fill the queue, then the request drops.
    repeat (8) step(1, 0, 0, 16'h0);
    check("t1_rd_drop", bus_rd, 0);
    check("t1_byte_pc", byte_pc, 16'h0000);
    check("t1_valid", data_valid, 1);

    // A single pop reopens fetching at the next address.
    step(1, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    check("t2_byte_pc", byte_pc, 16'h0001);
    check("t2_rd", bus_rd, 1);
    check("t2_addr", bus_addr, 16'h0004);
    step(1, 0, 0, 16'h0);

    // Flush during a slow bus cycle: read held, byte discarded, refetch at new PC.
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    check("t3_rd_pre", bus_rd, 1);
    check("t3_addr_pre", bus_addr, 16'h0005);
    step(0, 0, 1, 16'h0150);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    check("t3_rd_after_ack", bus_rd, 0);
    step(0, 0, 0, 16'h0);
    check("t3_rd", bus_rd, 1);
    check("t3_addr", bus_addr, 16'h0150);
    check("t3_byte_pc", byte_pc, 16'h0150);
    step(1, 0, 0, 16'h0);

    // Flush and ack in the same cycle with a byte already queued.
    check("t4_valid_pre", data_valid, 1);
    step(1, 1, 1, 16'h0200);
    check("t4_valid", data_valid, 0);
    check("t4_rd", bus_rd, 0);
    check("t4_byte_pc", byte_pc, 16'h0200);
    step(0, 0, 0, 16'h0);
    check("t4_rd_next", bus_rd, 1);
    check("t4_addr_next", bus_addr, 16'h0200);

    // PC wraparound at the top of the address space.
    step(1, 0, 1, 16'hFFFE);
    repeat (6) step(1, 0, 0, 16'h0);
    check("t5_rd_full", bus_rd, 0);
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    check("t5_byte_pc_wrap", byte_pc, 16'h0000);
    step(0, 1, 0, 16'h0);
    check("t5_byte_pc_next", byte_pc, 16'h0001);

`ifdef GB80_FETCH_HOLD_EN
    // Hold mid-burst: the acked read completes, nothing new starts until release.
    step(1, 0, 1, 16'h0300);
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    hold = 1'b1;
    step(1, 0, 0, 16'h0);
    check("t6_rd_hold", bus_rd, 0);
    repeat (2) begin
      step(1, 0, 0, 16'h0);
      check("t6_rd_held", bus_rd, 0);
    end
    step(1, 1, 0, 16'h0);
    check("t6_pop_in_hold", byte_pc, 16'h0301);
    check("t6_rd_still", bus_rd, 0);
    hold = 1'b0;
    step(1, 0, 0, 16'h0);
    check("t6_rd_resume", bus_rd, 1);
    check("t6_addr_resume", bus_addr, 16'h0302);
`endif

    repeat (8) step(0, 1, 0, 16'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
